// File: rtl/des_key_sched_seq_if.sv
// Handshake bundle between the key register file / round engine and the
// sequential DES/TDEA subkey scheduler.
interface des_key_sched_seq_if #(
  parameter int NUM_KEYS = 3
);
  logic                    load;
  logic                    mode;
  logic [64*NUM_KEYS-1:0]  key_in;
  logic [47:0]             subkey;
  logic                    subkey_valid;
  logic                    subkey_ready;
  logic [3:0]              round_idx;
  logic [1:0]              pass_idx;
  logic                    pass_dir;
  logic                    busy;
  logic                    done;

  modport master (
    output load, mode, key_in, subkey_ready,
    input  subkey, subkey_valid, round_idx, pass_idx, pass_dir, busy, done
  );

  modport slave (
    input  load, mode, key_in, subkey_ready,
    output subkey, subkey_valid, round_idx, pass_idx, pass_dir, busy, done
  );
endinterface

// File: rtl/des_key_sched_seq.sv
// Sequential DES/TDEA subkey scheduler: one 48-bit round subkey per handshake,
// E passes walk K1..K16 forward, D passes walk K16..K1 by rotating right.
module des_key_sched_seq #(
  parameter int NUM_KEYS = 3
) (
  input logic                i_clk,
  input logic                i_rst,
  des_key_sched_seq_if.slave ks
);
  localparam int PASSES = (NUM_KEYS == 1) ? 1 : 3;
  localparam int KW     = 64 * NUM_KEYS;

  // DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [1:0] SH [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return o;
  endfunction

  // C and D halves rotate independently by 1 or 2 positions.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n,
                                         input logic right);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (right) begin
      if (n == 2'd2) begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end else begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end
    end else begin
      if (n == 2'd2) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    return {c, d};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ROUND, S_FIN} state_t;

  state_t        r_state;
  logic [KW-1:0] r_key;
  logic          r_mode;
  logic [55:0]   r_cd;
  logic [47:0]   r_subkey;
  logic          r_valid;
  logic [3:0]    r_round;
  logic [1:0]    r_pass;
  logic          r_dir;
  logic          r_busy;
  logic          r_done;

  logic [63:0]   w_k1, w_k2, w_k3;
  logic [63:0]   w_pass_key;
  logic [55:0]   w_pc1;
  logic [55:0]   w_cd_nxt;
  logic [47:0]   w_subkey_nxt;
  logic          w_hs;
  logic          w_last;

  assign w_k1 = r_key[63:0];

  generate
    if (NUM_KEYS == 1) begin : g_k1
      assign w_k2 = w_k1;
      assign w_k3 = w_k1;
    end else if (NUM_KEYS == 2) begin : g_k2
      assign w_k2 = r_key[127:64];
      assign w_k3 = w_k1;
    end else begin : g_k3
      assign w_k2 = r_key[127:64];
      assign w_k3 = r_key[191:128];
    end
  endgenerate

  // Decrypt runs the keys in the opposite order: K3, K2, K1.
  always_comb begin
    w_pass_key = w_k1;
    if (PASSES == 3) begin
      case (r_pass)
        2'd0:    w_pass_key = r_mode ? w_k3 : w_k1;
        2'd1:    w_pass_key = w_k2;
        default: w_pass_key = r_mode ? w_k1 : w_k3;
      endcase
    end
  end

  assign w_pc1  = pc1(w_pass_key);
  assign w_hs   = r_valid & ks.subkey_ready;
  assign w_last = (r_round == 4'd15);

  // r_cd always holds the C/D pair behind the subkey currently presented.
  always_comb begin
    if (r_state == S_PREP)
      w_cd_nxt = r_dir ? w_pc1 : rot_cd(w_pc1, SH[0], 1'b0);
    else if (r_dir)
      w_cd_nxt = rot_cd(r_cd, SH[4'd15 - r_round], 1'b1);
    else
      w_cd_nxt = rot_cd(r_cd, SH[r_round + 4'd1], 1'b0);
  end

  assign w_subkey_nxt = pc2(w_cd_nxt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_mode   <= 1'b0;
      r_cd     <= '0;
      r_subkey <= '0;
      r_valid  <= 1'b0;
      r_round  <= '0;
      r_pass   <= '0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ks.load) begin
            r_key   <= ks.key_in;
            r_mode  <= ks.mode;
            r_pass  <= '0;
            r_dir   <= ks.mode;
            r_round <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_cd     <= w_cd_nxt;
          r_subkey <= w_subkey_nxt;
          r_valid  <= 1'b1;
          r_state  <= S_ROUND;
        end
        S_ROUND: begin
          if (w_hs) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_round <= '0;
              if (PASSES == 3 && r_pass != 2'd2) begin
                // Middle pass runs opposite to MODE.
                r_pass  <= r_pass + 2'd1;
                r_dir   <= r_mode ^ (r_pass == 2'd0);
                r_state <= S_PREP;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end
            end else begin
              r_cd     <= w_cd_nxt;
              r_subkey <= w_subkey_nxt;
              r_round  <= r_round + 4'd1;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ks.subkey       = r_subkey;
  assign ks.subkey_valid = r_valid;
  assign ks.round_idx    = r_round;
  assign ks.pass_idx     = r_pass;
  assign ks.pass_dir     = r_dir;
  assign ks.busy         = r_busy;
  assign ks.done         = r_done;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench for des_key_sched_seq: single DES and 3-key TDEA runs,
// back-pressure, mid-run reset and LOAD filtering.
module tb_des_key_sched_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K3 = 64'h0123456789ABCDEF;

  localparam logic [47:0] KS1 [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  localparam int TPC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int TPC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Cumulative left rotation after each round.
  localparam int TOT [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  des_key_sched_seq_if #(.NUM_KEYS(1)) if1 ();
  des_key_sched_seq_if #(.NUM_KEYS(3)) if3 ();

  des_key_sched_seq #(.NUM_KEYS(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .ks(if1));
  des_key_sched_seq #(.NUM_KEYS(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .ks(if3));

  int checks = 0;
  int failures = 0;

  logic [47:0] got1 [$];
  logic [47:0] e1 [$];
  int          first1, done1;
  logic [47:0] sk3 [$];
  logic [47:0] ref3 [$];
  logic [3:0]  rd3 [$];
  logic [1:0]  ps3 [$];
  logic        dr3 [$];
  int          done3, bub3, nst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-r subkey of an E schedule, from the total rotation count.
  function automatic logic [47:0] mks(input logic [63:0] key, input int r);
    logic [27:0] c, d;
    logic [55:0] x, cd;
    logic [47:0] o;
    c = '0; d = '0; o = '0;
    for (int i = 0; i < 28; i++) begin
      c = {c[26:0], key[6'(64 - TPC1[i])]};
      d = {d[26:0], key[6'(64 - TPC1[i + 28])]};
    end
    x = {c, c} << TOT[r]; c = x[55:28];
    x = {d, d} << TOT[r]; d = x[55:28];
    cd = {c, d};
    for (int i = 0; i < 48; i++) o = {o[46:0], cd[6'(56 - TPC2[i])]};
    return o;
  endfunction

  function automatic logic [47:0] exp3(input logic md, input int j);
    int p = j / 16;
    int r = j % 16;
    logic dir = md ^ (p == 1);
    logic [63:0] k = (p == 1) ? K2 : (((p == 0) ^ md) ? K1 : K3);
    int rr = dir ? 15 - r : r;
    if (k == K1) return KS1[rr];
    return mks(k, rr);
  endfunction

  // Called and returning at posedge+1; LOAD is driven in the current cycle.
  task automatic run1(input logic md, input logic glitch);
    got1.delete(); first1 = -1; done1 = -1;
    if1.mode = md; if1.key_in = K1; if1.load = 1'b1;
    @(posedge clk); #1;
    if1.load = 1'b0; if1.key_in = K2; if1.mode = ~md;
    for (int c = 1; c <= 60 && done1 < 0; c++) begin
      @(negedge clk);
      if (if1.subkey_valid && if1.subkey_ready) begin
        if (got1.size() == 0) first1 = c;
        got1.push_back(if1.subkey);
      end
      if (if1.done) done1 = c;
      @(posedge clk); #1;
      if1.load = glitch && (c + 1 == 5 || c + 1 == 10 || c + 1 == 18);
    end
  endtask

  task automatic run3(input logic md, input logic rnd);
    logic pv;
    logic [47:0] psk;
    logic [3:0] prd;
    logic [1:0] pps;
    logic pdr;
    sk3.delete(); rd3.delete(); ps3.delete(); dr3.delete();
    done3 = -1; bub3 = 0; nst = 0;
    pv = 1'b0; psk = '0; prd = '0; pps = '0; pdr = 1'b0;
    if3.mode = md; if3.key_in = {K3, K2, K1}; if3.load = 1'b1;
    if3.subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    if3.load = 1'b0; if3.key_in = '1;
    for (int c = 1; c <= 600 && done3 < 0; c++) begin
      @(negedge clk);
      if (pv) begin
        nst++;
        chk("stall_valid", 64'(if3.subkey_valid), 64'd1);
        chk("stall_subkey", 64'(if3.subkey), 64'(psk));
        chk("stall_round", 64'(if3.round_idx), 64'(prd));
        chk("stall_pass", 64'(if3.pass_idx), 64'(pps));
        chk("stall_dir", 64'(if3.pass_dir), 64'(pdr));
      end
      if (if3.subkey_valid && if3.subkey_ready) begin
        sk3.push_back(if3.subkey); rd3.push_back(if3.round_idx);
        ps3.push_back(if3.pass_idx); dr3.push_back(if3.pass_dir);
      end else if (!if3.subkey_valid && sk3.size() > 0 && sk3.size() < 48) begin
        bub3++;
      end
      pv = if3.subkey_valid && !if3.subkey_ready;
      psk = if3.subkey; prd = if3.round_idx; pps = if3.pass_idx; pdr = if3.pass_dir;
      if (if3.done) done3 = c;
      @(posedge clk); #1;
      if (rnd) if3.subkey_ready = 1'($urandom_range(0, 1));
    end
    if3.subkey_ready = 1'b1;
  endtask

  task automatic chk_zero3(input string tag);
    chk(tag, 64'({if3.subkey, if3.subkey_valid, if3.busy, if3.done,
                  if3.round_idx, if3.pass_idx, if3.pass_dir}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nh;
    logic hit;
    if1.load = 0; if1.mode = 0; if1.key_in = '0; if1.subkey_ready = 1'b1;
    if3.load = 0; if3.mode = 0; if3.key_in = '0; if3.subkey_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_zero3("reset3");
    chk("reset1", 64'({if1.subkey, if1.subkey_valid, if1.busy, if1.done,
                       if1.round_idx, if1.pass_idx, if1.pass_dir}), 64'd0);
    rst = 1'b0;

    // Single DES encrypt
    run1(1'b0, 1'b0);
    chk("des_e_first_cycle", 64'(first1), 64'd2);
    chk("des_e_count", 64'(got1.size()), 64'd16);
    chk("des_e_done_cycle", 64'(done1), 64'd18);
    for (int i = 0; i < 16 && i < got1.size(); i++)
      chk($sformatf("des_e_k%0d", i + 1), 64'(got1[i]), 64'(KS1[i]));
    e1 = got1;

    // Single DES decrypt
    run1(1'b1, 1'b0);
    chk("des_d_first_cycle", 64'(first1), 64'd2);
    chk("des_d_count", 64'(got1.size()), 64'd16);
    chk("des_d_done_cycle", 64'(done1), 64'd18);
    for (int i = 0; i < 16 && i < got1.size() && i < e1.size(); i++)
      chk($sformatf("des_d_rev%0d", i), 64'(got1[i]), 64'(e1[15 - i]));

    // LOAD pulses while busy and in the DONE cycle are ignored
    run1(1'b0, 1'b1);
    chk("glitch_count", 64'(got1.size()), 64'd16);
    chk("glitch_done_cycle", 64'(done1), 64'd18);
    for (int i = 0; i < 16 && i < got1.size(); i++)
      chk($sformatf("glitch_k%0d", i + 1), 64'(got1[i]), 64'(KS1[i]));
    chk("done_cycle_load_ignored", 64'(if1.busy), 64'd0);
    run1(1'b0, 1'b0);
    chk("b2b_first_cycle", 64'(first1), 64'd2);
    chk("b2b_first_key", 64'(got1.size() > 0 ? got1[0] : 48'd0), 64'(KS1[0]));
    chk("b2b_done_cycle", 64'(done1), 64'd18);

    // 3-key TDEA encrypt, READY held high
    run3(1'b0, 1'b0);
    chk("tdea_count", 64'(sk3.size()), 64'd48);
    chk("tdea_bubbles", 64'(bub3), 64'd2);
    chk("tdea_done_cycle", 64'(done3), 64'd52);
    for (int j = 0; j < 48 && j < sk3.size(); j++) begin
      chk($sformatf("tdea_sk%0d", j), 64'(sk3[j]), 64'(exp3(1'b0, j)));
      chk($sformatf("tdea_rd%0d", j), 64'(rd3[j]), 64'(j % 16));
      chk($sformatf("tdea_ps%0d", j), 64'(ps3[j]), 64'(j / 16));
      chk($sformatf("tdea_dir%0d", j), 64'(dr3[j]), 64'((j / 16) == 1));
    end
    ref3 = sk3;

    // Same run with random back-pressure
    run3(1'b0, 1'b1);
    chk("rnd_count", 64'(sk3.size()), 64'd48);
    chk("rnd_bubbles", 64'(bub3), 64'd2);
    chk("rnd_stalls_seen", 64'(nst > 0), 64'd1);
    chk("rnd_done_seen", 64'(done3 > 0), 64'd1);
    for (int j = 0; j < 48 && j < sk3.size() && j < ref3.size(); j++) begin
      chk($sformatf("rnd_sk%0d", j), 64'(sk3[j]), 64'(ref3[j]));
      chk($sformatf("rnd_rd%0d", j), 64'(rd3[j]), 64'(j % 16));
    end

    // 3-key TDEA decrypt: D,E,D over K3,K2,K1
    run3(1'b1, 1'b0);
    chk("tdea_d_count", 64'(sk3.size()), 64'd48);
    for (int j = 0; j < 48 && j < sk3.size(); j++) begin
      chk($sformatf("tdea_d_sk%0d", j), 64'(sk3[j]), 64'(exp3(1'b1, j)));
      chk($sformatf("tdea_d_dir%0d", j), 64'(dr3[j]), 64'((j / 16) != 1));
    end

    // Reset at the 7th handshake of pass 1
    if3.mode = 1'b0; if3.key_in = {K3, K2, K1}; if3.load = 1'b1;
    @(posedge clk); #1;
    if3.load = 1'b0;
    nh = 0; hit = 1'b0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      @(negedge clk);
      if (if3.subkey_valid && if3.subkey_ready) begin
        nh++;
        if (nh == 23) hit = 1'b1;
      end
      if (!hit) begin @(posedge clk); #1; end
    end
    chk("rst_point_reached", 64'(hit), 64'd1);
    chk("rst_point_pass", 64'(if3.pass_idx), 64'd1);
    chk("rst_point_round", 64'(if3.round_idx), 64'd6);
    rst = 1'b1;
    #1;
    chk_zero3("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_zero3("rst_hold");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run3(1'b0, 1'b0);
    chk("post_rst_first", 64'(sk3.size() > 0 ? sk3[0] : 48'd0), 64'(KS1[0]));
    chk("post_rst_count", 64'(sk3.size()), 64'd48);
    chk("post_rst_done_cycle", 64'(done3), 64'd52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
